axi_digest_tx: RTL and testbench
================================

# axi_digest_tx

AXI-Stream transmitter that returns a finished SHA-3 digest to the host. It sits after the Keccak-f permutation core, on the opposite side from the absorb-path stream receiver. On a `start` pulse it captures the 5x5x64 state and streams the first 224/256/384/512 bits as DATA_WIDTH-bit beats with TVALID/TREADY/TLAST/TID. The lane and bit order matches the order in which the receiver packs input words into the state.

## Interface
- DATA_WIDTH, 16, beat width in bits; legal values 8, 16, 32 (each divides 224).
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; D_in and mode valid in the same cycle.
- mode  in  2  digest select: 0=224, 1=256, 2=384, 3=512 bits.
- D_in  in  [4:0][4:0][63:0]  permuted Keccak state.
- TREADY  in  1  downstream ready.
- TVALID  out  1  beat valid.
- TDATA  out  DATA_WIDTH  beat payload.
- TLAST  out  1  final beat of digest.
- TID  out  2  echoes captured mode for the whole frame.
- busy  out  1  high from the capture edge until the final handshake edge.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- Flattened state: S[64*(5x+y)+63 : 64*(5x+y)] = D_in[x][y].
- Beat k carries S[DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k], so low-order bits go out first.
- Beat count N = L/DATA_WIDTH, where L is the digest length from mode. For DATA_WIDTH=16: N = 14/16/24/32 beats. For 8: N = 28/32/48/64. For 32: N = 7/8/12/16.
- Only S[511:0] is captured, in a 512-bit shift register. It shifts right by DATA_WIDTH on each handshake, so TDATA is always the low slice.
- Beat counter is 7 bits, clears on capture, increments on handshake. TLAST = TVALID && (cnt == N-1).
- FSM states:
  - IDLE: busy=0, TVALID=0.
  - SEND: busy=1, TVALID=1.
- Transitions:
  - IDLE to SEND on start: capture S[511:0] and mode, clear cnt.
  - SEND to SEND on a handshake with cnt != N-1: shift and increment.
  - SEND to IDLE on the handshake with TLAST=1: done=1 for the next cycle.
  - SEND holds on TREADY=0: TDATA, TLAST and TID stay stable. TVALID is never withdrawn without a handshake.
- start in SEND (including the final-handshake cycle) is ignored. No queueing.
- start is accepted in the first IDLE cycle, i.e. the cycle in which done is high.
- TVALID does not depend combinationally on TREADY.

## Timing
- Reset (ARESETn=0 at a rising edge) gives TVALID=0, TLAST=0, TDATA=0, TID=0, busy=0, done=0, cnt=0, FSM=IDLE. Shift-register contents are don't-care beyond TDATA=0.
- Reset in SEND aborts the frame. TVALID drops after that edge, and no TLAST or done is produced.
- Capture latency: start sampled at edge E0 gives TVALID=1, TDATA=beat 0, busy=1 in the cycle after E0.
- With TREADY held at 1: one beat per cycle. TLAST is high in cycle N after E0, TVALID=0 and done=1 after edge E0+N, so back-to-back start is possible at E0+N+1.
- Stall of M cycles extends the frame by exactly M cycles. No beat is duplicated or dropped.
- TID is constant from E0 until the frame ends. D_in and mode changes after E0 have no effect.

## Test plan
- Reset: hold ARESETn=0 for 3 cycles with start=1 -> all outputs 0, no TVALID afterwards until a start arrives after reset release.
- mode=1, DATA_WIDTH=16, D_in[0][0]=64'h0123456789ABCDEF, TREADY=1 -> 16 beats: TDATA CDEF, 89AB, 4567, 0123, then D_in[0][1] slices; TID=1; TLAST only on beat 16; done pulse one cycle after.
- mode=0 -> 14 beats with TLAST on beat 14 (D_in[0][3] bits 31:16), TID=0. mode=3 -> 32 beats ending with D_in[1][2] bits 63:48.
- Random TREADY backpressure (50%), mode=2 -> 24 accepted beats identical to the TREADY=1 run; TDATA/TLAST stable during every stall.
- start pulsed mid-frame with different D_in/mode -> ignored, frame unchanged. start in the done cycle -> new frame with TVALID in the next cycle.
- ARESETn=0 for 1 cycle after beat 5 of mode=1 -> TVALID=0 next cycle, no TLAST/done; a new start then sends a full 16-beat frame.

Source files
------------

// File: rtl/axi_digest_tx.sv
// axi_digest_tx: streams the leading 224/256/384/512 bits of a permuted
// Keccak state out as DATA_WIDTH-bit AXI-Stream beats, low-order bits first.
module axi_digest_tx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [4:0][4:0][63:0]      D_in,
    input  logic                       TREADY,
    output logic                       TVALID,
    output logic [DATA_WIDTH-1:0]      TDATA,
    output logic                       TLAST,
    output logic [1:0]                 TID,
    output logic                       busy,
    output logic                       done
);

    localparam int SR_W  = 512;
    localparam int CNT_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SR_W-1:0]    s_lo;
    logic [SR_W-1:0]    sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   last_idx;
    logic [1:0]         tid_q;
    logic               done_q;
    logic               capture;
    logic               advance;
    logic               finish;

    // Index of the final beat for a digest length selector.
    function automatic logic [CNT_W-1:0] last_beat(input logic [1:0] m);
        case (m)
            2'd0:    last_beat = CNT_W'(224 / DATA_WIDTH - 1);
            2'd1:    last_beat = CNT_W'(256 / DATA_WIDTH - 1);
            2'd2:    last_beat = CNT_W'(384 / DATA_WIDTH - 1);
            default: last_beat = CNT_W'(512 / DATA_WIDTH - 1);
        endcase
    endfunction

    // Flatten the first eight lanes in receiver packing order: lane 5x+y.
    always_comb begin
        s_lo = '0;
        for (int i = 0; i < 8; i++) begin
            s_lo[64*i +: 64] = D_in[i/5][i%5];
        end
    end

    // Lanes beyond the 512-bit digest window never leave the block.
    logic unused_lanes;
    assign unused_lanes = ^D_in;

    assign TVALID   = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign last_idx = last_beat(tid_q);
    assign TLAST    = TVALID && (cnt_q == last_idx);
    assign TDATA    = sr_q[DATA_WIDTH-1:0];
    assign TID      = tid_q;
    assign done     = done_q;

    // Next-state and datapath control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        capture = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SEND;
                    capture = 1'b1;
                end
            end
            SEND: begin
                if (TREADY) begin
                    if (cnt_q == last_idx) begin
                        state_d = IDLE;
                        finish  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!ARESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register, beat counter, frame ID and completion pulse.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            // NOTE: the shift register is cleared on reset only because TDATA must read zero afterwards.
            sr_q   <= '0;
            cnt_q  <= '0;
            tid_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (capture) begin
                sr_q  <= s_lo;
                tid_q <= mode;
                cnt_q <= '0;
            end else if (advance) begin
                sr_q  <= sr_q >> DATA_WIDTH;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi_digest_tx.sv
// tb_axi_digest_tx: directed self-checking bench for axi_digest_tx, DATA_WIDTH=16.
module tb_axi_digest_tx;

    typedef logic [4:0][4:0][63:0] state_t;

    localparam int BUDGET = 2000;

    logic              ACLK;
    logic              ARESETn;
    logic              start;
    logic [1:0]        mode;
    state_t            D_in;
    logic              TREADY;
    logic              TVALID;
    logic [15:0]       TDATA;
    logic              TLAST;
    logic [1:0]        TID;
    logic              busy;
    logic              done;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                acc;
    logic [15:0]       rec [64];
    state_t            st_a;
    state_t            st_b;

    axi_digest_tx #(.DATA_WIDTH(16)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .start   (start),
        .mode    (mode),
        .D_in    (D_in),
        .TREADY  (TREADY),
        .TVALID  (TVALID),
        .TDATA   (TDATA),
        .TLAST   (TLAST),
        .TID     (TID),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Beats per frame for a 16-bit beat: 224/256/384/512 bits.
    function automatic int beats_for(input logic [1:0] m);
        case (m)
            2'd0:    return 14;
            2'd1:    return 16;
            2'd2:    return 24;
            default: return 32;
        endcase
    endfunction

    // Beat k is bits [16k+15:16k] of the flattened state, lane index 5x+y.
    function automatic logic [15:0] exp_beat(input state_t st, input int k);
        int lane;
        lane = k / 4;
        return st[lane/5][lane%5][(k%4)*16 +: 16];
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, TVALID, 1'b0);
        check({tag, "_busy"},   busy,   1'b0);
        check({tag, "_tlast"},  TLAST,  1'b0);
    endtask

    // Present start with state/mode for one edge, then scramble the inputs.
    task automatic start_frame(input state_t st, input logic [1:0] m);
        D_in  = st;
        mode  = m;
        start = 1'b1;
        @(negedge ACLK);
        start = 1'b0;
        D_in  = st_b ^ st;
        mode  = ~m;
    endtask

    // Consume a frame beat by beat, checking every cycle against the model.
    task automatic stream(input state_t st, input logic [1:0] m, input int ready_pct,
                          input int glitch_at, input int stop_at);
        int   n;
        int   k;
        int   cyc;
        logic rdy;
        bit   aborted;
        n = beats_for(m);
        k = 0;
        cyc = 0;
        aborted = 1'b0;
        acc = 0;
        while (k < n && cyc < BUDGET) begin
            if (stop_at >= 0 && k == stop_at) begin
                aborted = 1'b1;
                break;
            end
            check($sformatf("m%0d_valid_b%0d", m, k), TVALID, 1'b1);
            check($sformatf("m%0d_busy_b%0d", m, k), busy, 1'b1);
            check($sformatf("m%0d_tid_b%0d", m, k), TID, m);
            check($sformatf("m%0d_data_b%0d", m, k), TDATA, exp_beat(st, k));
            check($sformatf("m%0d_last_b%0d", m, k), TLAST, (k == n - 1));
            check($sformatf("m%0d_done_b%0d", m, k), done, 1'b0);
            rdy    = ($urandom_range(0, 99) < ready_pct);
            TREADY = rdy;
            start  = (k == glitch_at);
            if (k == glitch_at) begin
                D_in = st_b;
                mode = ~m;
            end
            if (rdy) rec[k] = TDATA;
            @(negedge ACLK);
            if (rdy) begin
                k++;
                acc++;
            end
            cyc++;
        end
        start  = 1'b0;
        TREADY = 1'b1;
        if (!aborted) begin
            if (k < n) check($sformatf("m%0d_timeout", m), k, n);
            check($sformatf("m%0d_end_valid", m), TVALID, 1'b0);
            check($sformatf("m%0d_end_done", m), done, 1'b1);
            check($sformatf("m%0d_end_busy", m), busy, 1'b0);
            check($sformatf("m%0d_end_tlast", m), TLAST, 1'b0);
        end
    endtask

    initial begin
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                logic [7:0] idx;
                idx = 8'(5 * x + y);
                st_a[x][y] = {idx, 8'h33, idx, 8'h22, idx, 8'h11, idx, 8'h00};
                st_b[x][y] = {8'h80 | idx, 8'h77, idx, 8'h66, idx, 8'h55, idx, 8'h44};
            end
        end
        st_a[0][0] = 64'h0123456789ABCDEF;
        st_a[0][1] = 64'hFEDCBA9876543210;
        st_a[0][3] = 64'h1122334455667788;
        st_a[1][2] = 64'hDEADBEEFCAFEF00D;

        // Reset held for three edges with start asserted.
        ARESETn = 1'b0;
        start   = 1'b1;
        mode    = 2'd3;
        D_in    = st_a;
        TREADY  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge ACLK);
            @(negedge ACLK);
            check_idle("rst");
            check("rst_tdata", TDATA, 16'h0);
            check("rst_tid",   TID,   2'd0);
            check("rst_done",  done,  1'b0);
        end
        ARESETn = 1'b1;
        start   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check_idle("post_rst");
        end

        // mode=1, full-rate: 16 beats.
        start_frame(st_a, 2'd1);
        stream(st_a, 2'd1, 100, -1, -1);
        check("m1_count", acc, 16);
        check("m1_b0", rec[0], 16'hCDEF);
        check("m1_b1", rec[1], 16'h89AB);
        check("m1_b2", rec[2], 16'h4567);
        check("m1_b3", rec[3], 16'h0123);
        check("m1_b4", rec[4], 16'h3210);
        @(negedge ACLK);
        check("m1_done_pulse", done, 1'b0);
        check_idle("m1_after");

        // mode=0: 14 beats ending in D_in[0][3][31:16].
        start_frame(st_a, 2'd0);
        stream(st_a, 2'd0, 100, -1, -1);
        check("m0_count", acc, 14);
        check("m0_last", rec[13], 16'h5566);
        @(negedge ACLK);

        // mode=3: 32 beats ending in D_in[1][2][63:48].
        start_frame(st_a, 2'd3);
        stream(st_a, 2'd3, 100, -1, -1);
        check("m3_count", acc, 32);
        check("m3_last", rec[31], 16'hDEAD);
        @(negedge ACLK);

        // mode=2 under 50% backpressure: model checks every cycle including stalls.
        start_frame(st_b, 2'd2);
        stream(st_b, 2'd2, 50, -1, -1);
        check("m2_count", acc, 24);
        @(negedge ACLK);

        // start mid-frame is ignored.
        start_frame(st_a, 2'd1);
        stream(st_a, 2'd1, 100, 3, -1);
        check("glitch_mid_count", acc, 16);
        @(negedge ACLK);

        // start on the final-handshake cycle is ignored; start in the done cycle is taken.
        start_frame(st_a, 2'd1);
        stream(st_a, 2'd1, 100, 15, -1);
        check("glitch_last_count", acc, 16);
        start_frame(st_b, 2'd0);
        stream(st_b, 2'd0, 100, -1, -1);
        check("b2b_count", acc, 14);
        @(negedge ACLK);

        // Reset after five beats aborts the frame.
        start_frame(st_a, 2'd1);
        stream(st_a, 2'd1, 100, -1, 5);
        check("abort_beats", acc, 5);
        ARESETn = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        check_idle("abort");
        check("abort_done",  done,  1'b0);
        check("abort_tdata", TDATA, 16'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            check_idle("abort_hold");
            check("abort_hold_done", done, 1'b0);
        end
        start_frame(st_a, 2'd1);
        stream(st_a, 2'd1, 100, -1, -1);
        check("rerun_count", acc, 16);
        @(negedge ACLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
